// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each grant moves up to BURST words; one IDLE bubble separates grants.
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BURST   = 4,
    parameter int DW      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DW-1:0]              fifo_din,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_n;
    logic            grant_valid_n;
    logic [GW-1:0]   grant_id_n;
    logic [CW-1:0]   count, count_n;
    logic [GW-1:0]   last, last_n;

    logic            found;
    logic [GW-1:0]   sel;
    int unsigned     idx;
    logic            owner_valid;
    logic            transfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            count       <= '0;
            last        <= GW'(NUM_REQ - 1);
        end else begin
            state       <= state_n;
            grant_valid <= grant_valid_n;
            grant_id    <= grant_id_n;
            count       <= count_n;
            last        <= last_n;
        end
    end

    // Round-robin search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last) + i) % NUM_REQ;
            if (!found && req_valid[GW'(idx)]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
    end

    // Outputs are masked during reset so an aborted burst never writes.
    always_comb begin
        owner_valid   = req_valid[grant_id];
        transfer      = (state == GRANT) && owner_valid && !fifo_full && !reset;

        fifo_wr_en    = transfer;
        fifo_din      = '0;
        req_ready     = '0;
        state_n       = state;
        grant_valid_n = grant_valid;
        grant_id_n    = grant_id;
        count_n       = count;
        last_n        = last;

        if (transfer) begin
            fifo_din = req_data[grant_id*DW +: DW];
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = GRANT;
                    grant_valid_n = 1'b1;
                    grant_id_n    = sel;
                    count_n       = '0;
                end
            end
            GRANT: begin
                if (!reset) begin
                    req_ready[grant_id] = !fifo_full;
                end
                if ((transfer && count == CW'(BURST - 1)) || (!owner_valid && !fifo_full)) begin
                    state_n       = IDLE;
                    grant_valid_n = 1'b0;
                    grant_id_n    = '0;
                    count_n       = '0;
                    last_n        = grant_id;
                end else if (transfer) begin
                    count_n = count + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
